// File: rtl/count_seg_display_pkg.sv
// Shared constants and helpers for the two-digit down-counter display.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package count_disp_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    // Non-decimal inputs light nothing rather than a garbage pattern.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/count_seg_display_refresh.sv
// Digit refresh timer: holds each digit for REFRESH_DIV cycles, then flips digit_sel.
module refresh_divider #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic digit_sel
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refresh_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == LAST) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/count_seg_display.sv
// Registers the down-counter value, multiplexes its tens/ones digits onto a
// common-anode display and counts 0->15 wrap events.
module count_seg_display
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        count_in,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [1:0]        an,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [3:0] count_q;
    logic       tens;
    logic [3:0] ones;
    logic       digit_sel;
    logic [6:0] seg_d;
    logic [1:0] an_d;
    logic       wrap_det;

    refresh_divider #(.REFRESH_DIV(REFRESH_DIV)) u_refresh (
        .clk       (clk),
        .rst       (rst),
        .digit_sel (digit_sel)
    );

    // 4-bit input never exceeds 15, so the tens digit is a single bit.
    always_comb begin
        tens = 1'b0;
        ones = count_q;
        if (count_q >= 4'd10) begin
            tens = 1'b1;
            ones = count_q - 4'd10;
        end
    end

    always_comb begin
        seg_d = seg_enc(ones);
        an_d  = AN_ONES;
        if (digit_sel) begin
            seg_d = seg_enc({3'b000, tens});
            an_d  = tens ? AN_TENS : AN_OFF;
        end
        if (blank)
            an_d = AN_OFF;
    end

    // A wrap is only 0 -> 15; our own reset leaves count_q at 15, never 0.
    assign wrap_det = (count_q == 4'd0) && (count_in == 4'hF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= 4'hF;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            count_q    <= count_in;
            seg        <= seg_d;
            an         <= an_d;
            wrap_pulse <= wrap_det;
            if (wrap_det)
                wrap_cnt <= wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// Randomized bench for count_seg_display against a cycle-level arithmetic model.
module tb_count_seg_display;

    localparam int DIV = 4;
    localparam int WW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    count_in;
    logic          blank;
    logic [6:0]    seg;
    logic [1:0]    an;
    logic          wrap_pulse;
    logic [WW-1:0] wrap_cnt;

    count_seg_display #(.REFRESH_DIV(DIV), .WRAP_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] segtab [10];

    // model state: previous registered count, edges since reset, wraps seen
    int m_q   = 15;
    int k     = 0;
    int wraps = 0;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_p;
    int         e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] c, input logic b);
        int sel, tn, on;
        @(negedge clk);
        rst = r; count_in = c; blank = b;
        if (!r) begin
            e_seg = 7'h7F; e_an = 2'b11; e_p = 1'b0;
            m_q = 15; k = 0; wraps = 0;
        end else begin
            sel = (k / DIV) % 2;
            tn  = m_q / 10;
            on  = m_q % 10;
            e_seg = sel ? segtab[tn] : segtab[on];
            if (b)        e_an = 2'b11;
            else if (sel) e_an = (tn != 0) ? 2'b01 : 2'b11;
            else          e_an = 2'b10;
            e_p = (m_q == 0) && (c == 4'd15);
            if (e_p) wraps = (wraps + 1) % (1 << WW);
            m_q = c;
            k++;
        end
        e_cnt = wraps;
        @(posedge clk);
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(e_p));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(e_cnt));
    endtask

    initial begin
        logic [3:0] cur;
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        rst = 1'b0; count_in = 4'd7; blank = 1'b0;

        repeat (3) step(1'b0, 4'd7, 1'b0);
        repeat (16) step(1'b1, 4'd13, 1'b0);
        repeat (16) step(1'b1, 4'd5, 1'b0);

        // two full down-count passes then 15 again: exactly two wraps
        step(1'b0, 4'd15, 1'b0);
        for (int p = 0; p < 2; p++)
            for (int v = 15; v >= 0; v--) step(1'b1, 4'(v), 1'b0);
        step(1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd14, 1'b0);
        chk("wrap_total", 32'(wrap_cnt), 32'd2);

        // counter reset 6 -> 15 is not a wrap
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd15, 1'b0);
        chk("no_wrap_6_15", 32'(wrap_pulse), 32'd0);

        // five wraps with a 2-bit counter roll over to 1
        step(1'b0, 4'd15, 1'b0);
        repeat (5) begin
            step(1'b1, 4'd0, 1'b0);
            step(1'b1, 4'd15, 1'b0);
        end
        step(1'b1, 4'd15, 1'b0);
        chk("wrap_mod", 32'(wrap_cnt), 32'd1);

        repeat (12) step(1'b1, 4'd13, 1'b1);

        // reset landing in a tens phase
        step(1'b0, 4'd13, 1'b0);
        repeat (6) step(1'b1, 4'd13, 1'b0);
        step(1'b0, 4'd13, 1'b0);
        repeat (10) step(1'b1, 4'd12, 1'b0);

        cur = 4'd15;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 75) cur = cur - 4'd1;
            else                         cur = 4'($urandom_range(15));
            step(($urandom_range(99) != 0), cur, ($urandom_range(9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
- Downstream consumer of the 4-bit down counter (15→0, wraps to 15).
- Registers the counter value and converts it to two decimal digits (tens, ones).
- Time-multiplexes both digits onto a 2-digit common-anode 7-segment display.
- Detects and counts counter wrap events (0→15) for debug/LED use.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is held before switching to the other (≥2).
- WRAP_W, 8, width of the wrap-event counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- count_in  input  4  counter value from the down counter.
- blank  input  1  when 1, both anodes are off.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  anodes, active-low; an[0]=ones digit, an[1]=tens digit.
- wrap_pulse  output  1  one-cycle pulse on a detected 0→15 wrap.
- wrap_cnt  output  WRAP_W  number of wraps seen since reset; wraps modulo 2^WRAP_W.

Behaviour:
- Reset, applied while rst=0 at a clock edge:
  - count_q=4'hF (matches the counter's reset value).
  - refresh_cnt=0, digit_sel=0.
  - seg=7'h7F, an=2'b11 (display dark).
  - wrap_pulse=0, wrap_cnt=0.
- Reset asserted mid-operation clears all state on that edge. No partial update occurs.
- Stage 1: count_q<=count_in every cycle.
- BCD conversion, combinational from count_q:
  - If count_q≥10: tens=1, ones=count_q−10.
  - Otherwise: tens=0, ones=count_q.
- Refresh:
  - refresh_cnt counts 0..REFRESH_DIV−1.
  - At REFRESH_DIV−1 it returns to 0 and digit_sel toggles.
  - Each digit is therefore held for exactly REFRESH_DIV cycles.
- Stage 2 outputs, all registered:
  - digit_sel=0: seg<=enc(ones), an<=2'b10.
  - digit_sel=1: if tens=0 (leading zero), an<=2'b11; otherwise an<=2'b01. seg<=enc(tens).
  - blank=1 overrides the anodes: an<=2'b11. seg still updates.
- Latency: a count_in change sampled at edge N appears on seg/an at edge N+1 if the matching digit is selected. Otherwise it appears at the next digit switch.
- Wrap detect:
  - Condition: count_q==0 and count_in==15 at an edge.
  - On that edge: wrap_pulse<=1 and wrap_cnt<=wrap_cnt+1 (modulo 2^WRAP_W).
  - All other edges: wrap_pulse<=0.
- Not a wrap:
  - Counter reset from a non-zero value to 15 (count_q≠0).
  - The first 15 after our own reset (count_q resets to 15).
- Simultaneous wrap and digit switch are independent; both take effect on the same edge.
- Consecutive wraps each pulse; no minimum spacing is required.
- count_in is a synchronous same-clock source; no CDC logic.

Decomposition:
- Package count_disp_pkg holds:
  - The active-low segment constants SEG_0..SEG_9 and SEG_OFF=7'h7F.
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - The function that maps a 4-bit digit to its 7-bit segment code; values above 9 map to SEG_OFF.
  - The anode constants AN_ONES=2'b10, AN_TENS=2'b01, AN_OFF=2'b11.
- One sub-module: refresh_divider (REFRESH_DIV) owns refresh_cnt and outputs digit_sel.
- Everything else lives in the top module.

Test Plan:
- Reset behaviour (REFRESH_DIV=4): hold rst=0 for 3 cycles with count_in=7 → seg=7'h7F, an=2'b11, wrap_cnt=0, wrap_pulse=0. Release rst → digit_sel flips every 4 cycles.
- Two-digit value: count_in=13 held → ones phase shows an=2'b10 with seg=0110000 ('3'); tens phase shows an=2'b01 with seg=1111001 ('1'). Each phase lasts 4 cycles.
- Leading-zero blanking: count_in=5 → ones phase an=2'b10 with seg=0010010; tens phase an=2'b11.
- Wrap and counting: drive 15,14,…,0,15 twice, one value per cycle → wrap_pulse high for exactly one cycle, one cycle after each 0→15 sample. wrap_cnt ends at 2.
- Non-wrap 15: jump count_in 6→15 → no wrap_pulse. With WRAP_W=2, 5 wraps → wrap_cnt=1.
- blank and mid-operation reset: blank=1 → an=2'b11 while the digits keep cycling internally. Assert rst=0 during a tens phase → next edge gives an=2'b11, seg=7'h7F, refresh_cnt=0.
